// File: rtl/apb_to_lb_bridge.sv
// APB4 completer that maps one address window onto a CSR local bus.
// Each APB transfer becomes exactly one local write or read, bounded by a timeout.
module apb_to_lb_bridge #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                STRB_W    = DATA_W / 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                WIN_BITS  = 8,
    parameter int                TIMEOUT   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    input  logic [STRB_W-1:0] pstrb,
    output logic              pready,
    output logic [DATA_W-1:0] prdata,
    output logic              pslverr,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata,
    output logic              wen,
    output logic [STRB_W-1:0] wstrb,
    input  logic              wready,
    output logic [ADDR_W-1:0] raddr,
    output logic              ren,
    input  logic [DATA_W-1:0] rdata,
    input  logic              rvalid
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        WR,
        RD,
        DONE
    } state_t;

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic              seen_low, seen_low_next;
    logic              err_q, err_next;
    logic [DATA_W-1:0] prdata_q, prdata_next;
    logic [ADDR_W-1:0] waddr_q, waddr_next;
    logic [DATA_W-1:0] wdata_q, wdata_next;
    logic [STRB_W-1:0] wstrb_q, wstrb_next;
    logic [ADDR_W-1:0] raddr_q, raddr_next;

    logic              setup;
    logic              in_win;
    logic              aligned;
    logic              timed_out;
    logic [ADDR_W-1:0] local_addr;

    assign setup      = psel && !penable;
    assign in_win     = (paddr[ADDR_W-1:WIN_BITS] == BASE_ADDR[ADDR_W-1:WIN_BITS]);
    assign aligned    = (paddr[1:0] == 2'b00);
    assign timed_out  = (cnt == CNT_W'(TIMEOUT - 1));
    // Offset is the low window bits only; the base is never subtracted.
    assign local_addr = {{(ADDR_W - WIN_BITS){1'b0}}, paddr[WIN_BITS-1:0]};

    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        seen_low_next = seen_low;
        err_next      = 1'b0;
        prdata_next   = '0;
        waddr_next    = waddr_q;
        wdata_next    = wdata_q;
        wstrb_next    = wstrb_q;
        raddr_next    = raddr_q;
        case (state)
            IDLE: begin
                if (setup) begin
                    if (!in_win || !aligned) begin
                        state_next = DONE;
                        err_next   = 1'b1;
                    end else begin
                        cnt_next      = '0;
                        seen_low_next = 1'b0;
                        if (pwrite) begin
                            state_next = WR;
                            waddr_next = local_addr;
                            wdata_next = pwdata;
                            wstrb_next = pstrb;
                        end else begin
                            state_next = RD;
                            raddr_next = local_addr;
                        end
                    end
                end
            end
            WR: begin
                cnt_next = cnt + CNT_W'(1);
                if (wready) begin
                    state_next = DONE;
                end else if (timed_out) begin
                    state_next = DONE;
                    err_next   = 1'b1;
                end
            end
            RD: begin
                cnt_next = cnt + CNT_W'(1);
                if (!rvalid) begin
                    seen_low_next = 1'b1;
                end
                // An rvalid seen before any low cycle belongs to an earlier read.
                if (rvalid && seen_low) begin
                    state_next  = DONE;
                    prdata_next = rdata;
                end else if (timed_out) begin
                    state_next = DONE;
                    err_next   = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            seen_low <= 1'b0;
            err_q    <= 1'b0;
            prdata_q <= '0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            raddr_q  <= '0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            seen_low <= seen_low_next;
            err_q    <= err_next;
            prdata_q <= prdata_next;
            waddr_q  <= waddr_next;
            wdata_q  <= wdata_next;
            wstrb_q  <= wstrb_next;
            raddr_q  <= raddr_next;
        end
    end

    assign pready  = (state == DONE);
    assign pslverr = err_q;
    assign prdata  = prdata_q;
    assign wen     = (state == WR);
    assign ren     = (state == RD);
    assign waddr   = waddr_q;
    assign wdata   = wdata_q;
    assign wstrb   = wstrb_q;
    assign raddr   = raddr_q;

endmodule

// File: tb/tb_apb_to_lb_bridge.sv
// Randomized APB stimulus against a word-array CSR model; a monitor pops expected
// responses from a scoreboard queue whenever the bridge raises pready.
module tb_apb_to_lb_bridge;

    localparam int          ADDR_W   = 32;
    localparam int          DATA_W   = 32;
    localparam int          STRB_W   = 4;
    localparam int          WIN_BITS = 8;
    localparam int          TIMEOUT  = 16;
    localparam logic [31:0] BASE     = 32'h4000_1000;
    localparam int unsigned NEVER    = 99;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [ADDR_W-1:0] paddr = '0;
    logic [DATA_W-1:0] pwdata = '0;
    logic [STRB_W-1:0] pstrb = '0;
    logic              pready, pslverr, wen, ren;
    logic [DATA_W-1:0] prdata, wdata, rdata;
    logic [ADDR_W-1:0] waddr, raddr;
    logic [STRB_W-1:0] wstrb;
    logic              wready, rvalid;

    always #5 clk = ~clk;

    apb_to_lb_bridge #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STRB_W(STRB_W),
        .BASE_ADDR(BASE), .WIN_BITS(WIN_BITS), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pready(pready),
        .prdata(prdata), .pslverr(pslverr), .waddr(waddr), .wdata(wdata),
        .wen(wen), .wstrb(wstrb), .wready(wready), .raddr(raddr), .ren(ren),
        .rdata(rdata), .rvalid(rvalid)
    );

    typedef struct {
        logic        err;
        logic [31:0] data;
        int unsigned due;
        int unsigned act;
        logic [31:0] laddr;
    } exp_t;

    exp_t        sb[$];
    int unsigned vectors = 0, miscompares = 0;
    int unsigned cyc = 0;
    logic [31:0] ref_mem[64];
    logic [31:0] lb_mem[64];
    int unsigned act_total = 0;
    logic [31:0] seen_addr = '0;
    int unsigned kn_wdel = 0, kn_rv = 1;
    bit          kn_hold = 1'b0;
    bit          m_hold = 1'b0;
    bit          chk_rst = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Local-bus responder: wready after kn_wdel cycles; rvalid keeps its old level in the
    // first ren cycle (possibly stale-high), goes low, then high at ren cycle kn_rv.
    initial begin
        int unsigned k;
        bit was, lvl;
        k = 0; was = 0; lvl = 0;
        for (int i = 0; i < 64; i++) lb_mem[i] = '0;
        wready = 1'b0; rvalid = 1'b0; rdata = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                k = 0; was = 0; lvl = 0;
                wready = 1'b0; rvalid = 1'b0; rdata = $urandom;
            end else begin
                if (wen || ren) begin
                    k = was ? k + 1 : 0;
                    was = 1;
                    act_total++;
                    seen_addr = wen ? waddr : raddr;
                end else begin
                    was = 0;
                end
                wready = wen && (k >= kn_wdel);
                if (ren) begin
                    if (k == 0) begin
                        rvalid = lvl;
                        rdata  = $urandom;
                    end else if (k >= kn_rv) begin
                        rvalid = 1'b1;
                        rdata  = lb_mem[raddr[WIN_BITS-1:2]];
                        lvl    = kn_hold;
                    end else begin
                        rvalid = 1'b0;
                        rdata  = $urandom;
                    end
                end else begin
                    rvalid = lvl;
                    rdata  = $urandom;
                end
                if (wen && wready) begin
                    for (int b = 0; b < 4; b++)
                        if (wstrb[b]) lb_mem[waddr[WIN_BITS-1:2]][8*b +: 8] = wdata[8*b +: 8];
                end
            end
        end
    end

    // Monitor: sole owner of the comparison counters.
    initial begin
        exp_t        e;
        int unsigned act_base;
        act_base = 0;
        forever begin
            @(negedge clk);
            if (rst) act_base = act_total;
            if (wen === 1'b1 && ren === 1'b1) check("wen_ren_exclusive", 32'd1, 32'd0);
            if (chk_rst) begin
                check("rst_pready", {31'd0, pready}, 32'd0);
                check("rst_pslverr", {31'd0, pslverr}, 32'd0);
                check("rst_wen", {31'd0, wen}, 32'd0);
                check("rst_ren", {31'd0, ren}, 32'd0);
                check("rst_prdata", prdata, 32'd0);
                check("rst_waddr", waddr, 32'd0);
                check("rst_wdata", wdata, 32'd0);
                check("rst_wstrb", {28'd0, wstrb}, 32'd0);
                check("rst_raddr", raddr, 32'd0);
            end
            if (pready === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_pready", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("pslverr", {31'd0, pslverr}, {31'd0, e.err});
                    check("prdata", prdata, e.data);
                    check("latency", cyc, e.due);
                    check("local_cycles", act_total - act_base, e.act);
                    if (e.act > 0) check("local_addr", seen_addr, e.laddr);
                end
                act_base = act_total;
            end else if (sb.size() > 0 && cyc > sb[0].due + 4) begin
                e = sb.pop_front();
                check("pready_wait_expired", cyc, e.due);
            end
        end
    end

    task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] st, input int unsigned wdel, input int unsigned rv,
                        input bit hold);
        exp_t        e;
        int unsigned lat, off;
        @(negedge clk);
        kn_wdel = wdel; kn_rv = rv; kn_hold = hold;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd; pstrb = st;
        off     = addr[7:2];
        e.laddr = {24'd0, addr[7:0]};
        e.data  = '0;
        if (addr[31:WIN_BITS] != BASE[31:WIN_BITS] || addr[1:0] != 2'b00) begin
            e.err = 1'b1; lat = 1; e.act = 0;
        end else if (wr) begin
            if (wdel >= TIMEOUT) begin
                e.err = 1'b1; lat = TIMEOUT + 1; e.act = TIMEOUT;
            end else begin
                e.err = 1'b0; lat = wdel + 2; e.act = wdel + 1;
                for (int b = 0; b < 4; b++)
                    if (st[b]) ref_mem[off][8*b +: 8] = wd[8*b +: 8];
            end
        end else begin
            if (rv >= TIMEOUT) begin
                e.err = 1'b1; lat = TIMEOUT + 1; e.act = TIMEOUT;
            end else begin
                e.err = 1'b0; lat = rv + 2; e.act = rv + 1;
                e.data = ref_mem[off];
                m_hold = hold;
            end
        end
        e.due = cyc + lat;
        sb.push_back(e);
        @(negedge clk);
        penable = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (pready === 1'b1) break;
            @(negedge clk);
        end
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) begin
            @(negedge clk);
            psel = 1'b0; penable = 1'b0;
        end
    endtask

    initial begin
        bit          wr;
        logic [31:0] a;
        int unsigned sel, wdel, rv;
        for (int i = 0; i < 64; i++) ref_mem[i] = '0;

        repeat (3) @(posedge clk);
        #2 chk_rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0; chk_rst = 1'b0;

        xfer(1, BASE + 32'h04, 32'h0000_001B, 4'hF, 0, 1, 0);
        xfer(1, BASE + 32'h0C, 32'h1234_5678, 4'hF, 1, 1, 0);
        idle(1);
        xfer(0, BASE + 32'h0C, '0, 4'h0, 0, 1, 1);
        xfer(0, BASE + 32'h04, '0, 4'h0, 0, 2, 0);
        xfer(1, BASE + 32'h100, 32'hDEAD_BEEF, 4'hF, 0, 1, 0);
        xfer(0, BASE + 32'h02, '0, 4'h0, 0, 1, 0);
        xfer(1, BASE ^ 32'h1000_0000, 32'hCAFE_F00D, 4'hF, 0, 1, 0);
        xfer(0, BASE + 32'h08, '0, 4'h0, 0, NEVER, 0);
        xfer(1, BASE + 32'h08, 32'h5555_AAAA, 4'hF, NEVER, 1, 0);
        xfer(1, BASE + 32'h04, 32'hFFFF_FFFF, 4'h0, 2, 1, 0);
        xfer(0, BASE + 32'h04, '0, 4'h0, 0, 3, 0);
        idle(2);

        // Reset asserted during the second RD cycle of a read that never completes.
        @(negedge clk);
        kn_rv = NEVER; kn_wdel = 0; kn_hold = 0;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = BASE + 32'h08;
        @(negedge clk);
        penable = 1'b1;
        @(posedge clk);
        #2 rst = 1'b1; psel = 1'b0; penable = 1'b0;
        @(posedge clk);
        #2 rst = 1'b0; chk_rst = 1'b1; m_hold = 1'b0;
        @(posedge clk);
        #1 chk_rst = 1'b0;
        xfer(0, BASE + 32'h0C, '0, 4'h0, 0, 1, 0);

        for (int n = 0; n < 200; n++) begin
            wr   = 1'($urandom_range(0, 1));
            a    = BASE + 32'($urandom_range(0, 15) * 4);
            sel  = $urandom_range(0, 99);
            wdel = $urandom_range(0, 3);
            rv   = $urandom_range(m_hold ? 2 : 1, 4);
            if (sel < 4) a[1:0] = 2'($urandom_range(1, 3));
            else if (sel < 8) a = a + 32'($urandom_range(1, 255) * 256);
            else if (sel < 11) begin wdel = NEVER; rv = NEVER; end
            xfer(wr, a, $urandom, 4'($urandom), wdel, rv, 1'($urandom_range(0, 1)));
            idle($urandom_range(0, 2));
        end

        idle(2);
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
